data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, write-no-allocate data cache.
- Sits between the CPU memory stage (address = aluresultm, write data = writedatam) and the backing data memory.
- Read hits return data combinationally in the same cycle.
- Read misses and all writes go to backing memory over a ready-handshake, and hold the pipeline with a stall output for the duration.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDRESS_WIDTH, 32, byte address width.
- INDEX_BITS, 3, log2 of line count (8 one-word lines).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] are ignored (word-aligned).
- cpu_re  in  1  read request.
- cpu_we  in  1  write request.
- cpu_be  in  4  byte enables for writes; bit i selects byte i.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_rdata  out  DATA_WIDTH  read data.
- stall  out  1  CPU must hold its request and freeze while high.
- mem_addr  out  ADDRESS_WIDTH  word-aligned backing address, {cpu_addr[31:2],2'b00}.
- mem_re  out  1  backing read strobe.
- mem_we  out  1  backing write strobe.
- mem_be  out  4  backing byte enables.
- mem_wdata  out  DATA_WIDTH  backing write data.
- mem_rdata  in  DATA_WIDTH  backing read data, valid when mem_ready is high.
- mem_ready  in  1  backing access complete this cycle.

Behaviour:
- Address split: index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2].
- Storage per line: valid bit, tag, data word.
- hit = valid[index] && stored_tag == tag.
- Reset (async): all valid bits cleared, state=IDLE, stall=0, mem_re=0, mem_we=0, mem_be=0, cpu_rdata=0. Tag and data arrays are not reset.
- Reset asserted mid-FETCH or mid-WRITE: aborts immediately. mem_re/mem_we drop combinationally with reset, no line is modified, and a mem_ready arriving in the same cycle is ignored.
- IDLE, cpu_we=1 (takes priority over cpu_re if both are high): stall=1, mem strobes stay 0 this cycle, next state WRITE.
- IDLE, cpu_re=1, hit: cpu_rdata = line data (combinational), stall=0, state stays IDLE. Zero added latency.
- IDLE, cpu_re=1, miss: stall=1, next state FETCH.
- IDLE, no request: stall=0, cpu_rdata=0. A mem_ready pulse is ignored.
- FETCH:
  - mem_re=1, mem_addr driven, stall = ~mem_ready.
  - On mem_ready: cpu_rdata = mem_rdata (bypass, same cycle). At that edge the line is written (valid=1, tag, data) and the state returns to IDLE.
- WRITE:
  - mem_we=1, mem_be=cpu_be, mem_wdata=cpu_wdata, stall = ~mem_ready.
  - On mem_ready with hit: only the enabled bytes of the line data are merged, at that edge. State returns to IDLE.
  - On mem_ready with miss: line unchanged (no allocate). State returns to IDLE.
- Outside FETCH/WRITE: mem_re=0, mem_we=0, mem_be=0.
- Request hold: the CPU holds cpu_* stable while stall=1. The cache reuses the live cpu_* inputs rather than latching them.
- Minimum cost of a miss or write is 2 cycles (IDLE cycle plus a FETCH/WRITE cycle with mem_ready=1). Backing latency is unbounded.
- Aliasing: same index with a different tag evicts the old line on a read-miss fill only.
- State encoding: 2 bits (IDLE=0, FETCH=1, WRITE=2); 3 is illegal and recovers to IDLE next cycle with stall=0.

Test Plan:
- Cold read miss: reset, then read 0x10. mem_rdata=0xDEADBEEF with mem_ready in the 3rd FETCH cycle → stall high 3 cycles (IDLE + 2 FETCH), low with cpu_rdata=0xDEADBEEF in the mem_ready cycle. A subsequent read of 0x10 is a hit: stall=0, same data, mem_re never asserted.
- Write hit with byte mask: line 0x10 = 0xDEADBEEF; write 0x10, be=4'b0011, wdata=0x00001234, mem_ready after 1 cycle → mem_we/mem_be=0011 seen. A later read of 0x10 hits with 0xDEAD1234.
- Write miss no-allocate: write 0x40 = 0xCAFEF00D → mem_we pulse. A following read of 0x40 misses (mem_re asserted).
- Conflict eviction: fill 0x10, then read 0x30 (same index 4, different tag) → miss and refill. Re-read of 0x10 misses again.
- Reset mid-FETCH: assert rst in the 2nd FETCH cycle with mem_ready=1 → mem_re drops immediately, state IDLE, stall=0. A read of that address afterwards misses.
- Simultaneous cpu_re & cpu_we on a hit line → treated as a write (mem_we asserted, mem_re never asserted).

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, write-no-allocate data cache.
// Read hits answer combinationally. Read misses and every write go to the
// backing memory over a ready handshake, and stall the pipeline until
// mem_ready arrives. The live cpu_* request is reused throughout a miss or
// write because the CPU holds it stable while stall is high.
module data_cache #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INDEX_BITS    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [3:0]               cpu_be,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  fill_en;
  logic                  merge_en;
  logic [DATA_WIDTH-1:0] merged;

  // Byte offset bits never reach the cache; the backing address is word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign index     = cpu_addr[INDEX_BITS+1:2];
  assign tag       = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign hit       = valid_q[index] && (tag_q[index] == tag);
  assign mem_addr  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  // Line updates only happen on a completed handshake; reset suppresses them
  // so an abort in the same cycle as mem_ready leaves the line untouched.
  assign fill_en  = !rst && (state_q == FETCH) && mem_ready;
  assign merge_en = !rst && (state_q == WRITE) && mem_ready && hit;

  // Byte-masked merge of the write data into the currently indexed line.
  always_comb begin
    merged = data_q[index];
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) begin
        merged[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
    end
  end

  // Next state and all handshake/CPU outputs.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    cpu_rdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          // Writes win over reads; the strobe starts next cycle.
          stall   = 1'b1;
          state_d = WRITE;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = data_q[index];
          end else begin
            stall   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        mem_re = 1'b1;
        stall  = !mem_ready;
        if (mem_ready) begin
          // Bypass the returning word so the CPU is released this cycle.
          cpu_rdata = mem_rdata;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        mem_be = cpu_be;
        stall  = !mem_ready;
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset takes effect on the outputs immediately, not at the next edge.
    if (rst) begin
      stall     = 1'b0;
      cpu_rdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
    end
  end

  // State register and valid bits, both cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: no reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_rdata;
    end else if (merge_en) begin
      data_q[index] <= merged;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, hand-written
// reset/idle sequences and randomized traffic against a transaction-level model.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  data_cache #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .INDEX_BITS    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory, word keyed; unwritten words return an address pattern.
  logic [31:0] backing [int unsigned];

  function automatic logic [31:0] bk_read(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (backing.exists(k)) return backing[k];
    return (k * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  task automatic bk_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = bk_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    backing[a >> 2] = w;
  endtask

  // Reference model: line = word address mod 8, tag = byte address / 32.
  bit          m_valid [8];
  int unsigned m_tag   [8];
  logic [31:0] m_data  [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CPU transaction: holds the request until stall drops, plays the
  // backing memory with mem_ready after `lat` strobe cycles.
  task automatic xact(input logic re, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata, input int lat,
                      output int stalls, output bit saw_re, output bit saw_we,
                      output logic [3:0] saw_be, output logic [31:0] saw_addr,
                      output logic [31:0] rdata);
    int mem_cycles;
    bit done;
    mem_cycles = 0; done = 1'b0; stalls = 0; saw_re = 1'b0; saw_we = 1'b0;
    saw_be = '0; saw_addr = '0; rdata = '0;
    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (mem_re || mem_we) begin
        if (mem_re) saw_re = 1'b1;
        if (mem_we) begin saw_we = 1'b1; saw_be = mem_be; end
        saw_addr = mem_addr;
        if (mem_cycles == lat) begin
          mem_ready = 1'b1;
          if (mem_we) bk_write(mem_addr, mem_be, mem_wdata);
          else mem_rdata = bk_read(mem_addr);
        end
        mem_cycles++;
      end
      #1;
      if (!stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
      end else begin
        stalls++;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    chk("xact_completes", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  // Randomized/model-checked transaction.
  task automatic model_xact(input logic re, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata, input int lat);
    int unsigned l, t;
    bit is_read, hit, exp_re;
    int exp_stalls;
    logic [31:0] exp_data, m;
    int st; bit sr, sw; logic [3:0] sb; logic [31:0] sa, rd;
    l = (addr / 4) % 8;
    t = addr / 32;
    is_read = re && !we;
    hit = m_valid[l] && (m_tag[l] == t);
    exp_re = is_read && !hit;
    exp_stalls = (we || exp_re) ? lat + 1 : 0;
    exp_data = is_read ? (hit ? m_data[l] : bk_read(addr)) : 32'h0;
    xact(re, we, addr, be, wdata, lat, st, sr, sw, sb, sa, rd);
    chk($sformatf("rnd_stalls a=%h re=%0d we=%0d", addr, re, we), st, exp_stalls);
    chk($sformatf("rnd_mem_re a=%h", addr), {31'b0, sr}, {31'b0, exp_re});
    chk($sformatf("rnd_mem_we a=%h", addr), {31'b0, sw}, {31'b0, we});
    if (we) chk($sformatf("rnd_mem_be a=%h", addr), {28'b0, sb}, {28'b0, be});
    if (we || exp_re) chk($sformatf("rnd_mem_addr a=%h", addr), sa, addr & ~32'h3);
    if (!we) chk($sformatf("rnd_rdata a=%h", addr), rd, exp_data);
    if (exp_re) begin
      m_valid[l] = 1'b1; m_tag[l] = t; m_data[l] = exp_data;
    end else if (we && hit) begin
      m = 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
      m_data[l] = (m_data[l] & ~m) | (wdata & m);
    end
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    int          exp_stalls;
    bit          exp_re;
    bit          exp_we;
    logic [3:0]  exp_be;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int st; bit sr, sw; logic [3:0] sb; logic [31:0] sa, rd;
    logic r_re, r_we; logic [31:0] r_addr; int op;

    //          re we addr    be    wdata         lat stl re we be    chk data
    vecs[0]  = '{1, 0, 32'h10, 4'h0, 32'h0,        2, 3, 1, 0, 4'h0, 1, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 32'h10, 4'h0, 32'h0,        0, 0, 0, 0, 4'h0, 1, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 32'h10, 4'h3, 32'h00001234, 1, 2, 0, 1, 4'h3, 0, 32'h0};
    vecs[3]  = '{1, 0, 32'h10, 4'h0, 32'h0,        0, 0, 0, 0, 4'h0, 1, 32'hDEAD1234};
    vecs[4]  = '{0, 1, 32'h40, 4'hF, 32'hCAFEF00D, 0, 1, 0, 1, 4'hF, 0, 32'h0};
    vecs[5]  = '{1, 0, 32'h40, 4'h0, 32'h0,        0, 1, 1, 0, 4'h0, 1, 32'hCAFEF00D};
    vecs[6]  = '{1, 0, 32'h30, 4'h0, 32'h0,        1, 2, 1, 0, 4'h0, 1, 32'h30303030};
    vecs[7]  = '{1, 0, 32'h10, 4'h0, 32'h0,        0, 1, 1, 0, 4'h0, 1, 32'hDEAD1234};
    vecs[8]  = '{1, 1, 32'h10, 4'hC, 32'hBEEF0000, 0, 1, 0, 1, 4'hC, 0, 32'h0};
    vecs[9]  = '{1, 0, 32'h12, 4'h0, 32'h0,        0, 0, 0, 0, 4'h0, 1, 32'hBEEF1234};
    vecs[10] = '{0, 1, 32'h30, 4'hF, 32'h11111111, 0, 1, 0, 1, 4'hF, 0, 32'h0};
    vecs[11] = '{1, 0, 32'h30, 4'h0, 32'h0,        0, 1, 1, 0, 4'h0, 1, 32'h11111111};

    backing[32'h10 >> 2] = 32'hDEADBEEF;
    backing[32'h30 >> 2] = 32'h30303030;

    rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_be = '0;
    cpu_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_mem_re", {31'b0, mem_re}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset_mem_be", {28'b0, mem_be}, 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);

    // Directed vectors from the test plan.
    for (int i = 0; i < 12; i++) begin
      xact(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].lat,
           st, sr, sw, sb, sa, rd);
      chk($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
      chk($sformatf("vec%0d_mem_re", i), {31'b0, sr}, {31'b0, vecs[i].exp_re});
      chk($sformatf("vec%0d_mem_we", i), {31'b0, sw}, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) chk($sformatf("vec%0d_mem_be", i), {28'b0, sb}, {28'b0, vecs[i].exp_be});
      if (vecs[i].exp_re || vecs[i].exp_we)
        chk($sformatf("vec%0d_mem_addr", i), sa, vecs[i].addr & ~32'h3);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
    end

    // A stray mem_ready in IDLE with no request must be ignored.
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("idle_ready_stall", {31'b0, stall}, 32'd0);
    chk("idle_ready_rdata", cpu_rdata, 32'd0);
    chk("idle_ready_mem_re", {31'b0, mem_re}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    xact(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 0, st, sr, sw, sb, sa, rd);
    chk("idle_ready_hit_stalls", st, 0);
    chk("idle_ready_hit_mem_re", {31'b0, sr}, 32'd0);
    chk("idle_ready_hit_rdata", rd, 32'h11111111);

    // Reset in the second FETCH cycle, coincident with mem_ready.
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h58;
    #1;
    chk("abort_idle_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1;
    chk("abort_fetch1_mem_re", {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A; rst = 1'b1;
    #1;
    chk("abort_mem_re_drop", {31'b0, mem_re}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_re = 1'b0; mem_ready = 1'b0;
    #1;
    chk("abort_after_mem_re", {31'b0, mem_re}, 32'd0);
    chk("abort_after_stall", {31'b0, stall}, 32'd0);
    model_clear();
    model_xact(1'b1, 1'b0, 32'h58, 4'h0, 32'h0, 1);
    model_xact(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 0);

    // Randomized traffic over a small address window to force conflicts.
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      r_re = (op <= 4) || (op == 8);
      r_we = (op >= 5) && (op <= 8);
      r_addr = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      model_xact(r_re, r_we, r_addr, 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
